// File: rtl/melody_pkg.sv
// rtl/melody_pkg.sv - note codes, sequencer states and song ROM for the melody sequencer
package melody_pkg;

  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_C4   = 4'd1;
  localparam logic [3:0] NOTE_D4   = 4'd2;
  localparam logic [3:0] NOTE_E4   = 4'd3;
  localparam logic [3:0] NOTE_F4   = 4'd4;
  localparam logic [3:0] NOTE_G4   = 4'd5;
  localparam logic [3:0] NOTE_A4   = 4'd6;
  localparam logic [3:0] NOTE_B4   = 4'd7;
  localparam logic [3:0] NOTE_C5   = 4'd8;
  localparam logic [3:0] NOTE_END  = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_t;

  // Frequency in Hz for each playable code; rests and unused codes give 0.
  function automatic int unsigned note_hz(input logic [3:0] code);
    int unsigned f;
    case (code)
      NOTE_C4: f = 262;
      NOTE_D4: f = 294;
      NOTE_E4: f = 330;
      NOTE_F4: f = 349;
      NOTE_G4: f = 392;
      NOTE_A4: f = 440;
      NOTE_B4: f = 494;
      NOTE_C5: f = 523;
      default: f = 0;
    endcase
    return f;
  endfunction

  // Half-period terminal count of the tone divider for a note code.
  function automatic int unsigned note_tc(input logic [3:0] code, input int unsigned clk_hz);
    int unsigned f;
    f = note_hz(code);
    if (f == 0) return 0;
    return clk_hz / (2 * f) - 1;
  endfunction

  function automatic logic is_tone(input logic [3:0] code);
    return (code >= NOTE_C4) && (code <= NOTE_C5);
  endfunction

  // Default song: C4..C5 at two beats each, a one-beat rest, then end markers.
  function automatic logic [7:0] song_rom(input logic [7:0] addr);
    logic [7:0] entry;
    if (addr < 8'd8)       entry = {addr[3:0] + 4'd1, 4'd2};
    else if (addr == 8'd8) entry = {NOTE_REST, 4'd1};
    else                   entry = {NOTE_END, 4'd0};
    return entry;
  endfunction

endpackage

// File: rtl/tone_divider.sv
// rtl/tone_divider.sv - loadable-count square-wave divider driving the buzzer
module tone_divider #(
  parameter int TC_W = 17
) (
  input  logic            clk_50MHz,
  input  logic            reset_button,
  input  logic            clear,
  input  logic            enable,
  input  logic [TC_W-1:0] tc,
  output logic            buzzer
);

  logic [TC_W-1:0] cnt;

  // Count 0..tc and flip the output on each wrap; clear forces a silent, phase-zero start.
  always_ff @(posedge clk_50MHz) begin
    if (reset_button || clear) begin
      cnt    <= '0;
      buzzer <= 1'b0;
    end else if (enable) begin
      if (cnt == tc) begin
        cnt    <= '0;
        buzzer <= ~buzzer;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - song ROM sequencer with note/gap timing and start/stop/loop control
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 1_250_000,
  parameter int SONG_LEN    = 16
) (
  input  logic       clk_50MHz,
  input  logic       reset_button,
  input  logic       start,
  input  logic       stop,
  input  logic       loop_en,
  output logic       buzzer,
  output logic       busy,
  output logic       done,
  output logic [3:0] note_code
);

  // One extra address bit so the address can reach SONG_LEN and be seen as end of ROM.
  localparam int ADDR_W  = $clog2(SONG_LEN + 1);
  localparam int TC_MAX  = int'(note_tc(NOTE_C4, CLK_HZ));
  localparam int TC_W    = (TC_MAX > 0) ? $clog2(TC_MAX + 1) : 1;
  localparam int DUR_MAX = (15 * BEAT_CYCLES > GAP_CYCLES) ? 15 * BEAT_CYCLES : GAP_CYCLES;
  localparam int DUR_W   = $clog2(DUR_MAX + 1);
  localparam logic [DUR_W-1:0] BEAT_LEN = DUR_W'(BEAT_CYCLES);
  localparam logic [DUR_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? DUR_W'(GAP_CYCLES - 1) : DUR_W'(0);

  state_t            state, next_state;
  logic [ADDR_W-1:0] addr;
  logic [DUR_W-1:0]  dur_cnt;
  logic [3:0]        cur_code;
  logic [7:0]        rom_entry;
  logic [3:0]        beats_eff;
  logic [DUR_W-1:0]  play_load;
  logic              load_end;
  logic              dur_zero;
  logic              tone_en;
  logic              tone_clear;
  logic [TC_W-1:0]   tc;

  assign rom_entry = song_rom(8'(addr));
  assign load_end  = (rom_entry[7:4] == NOTE_END) || (addr == ADDR_W'(SONG_LEN));
  assign beats_eff = (rom_entry[3:0] == 4'd0) ? 4'd1 : rom_entry[3:0];
  assign play_load = DUR_W'(beats_eff) * BEAT_LEN - DUR_W'(1);
  assign dur_zero  = (dur_cnt == '0);
  assign tc        = TC_W'(note_tc(cur_code, CLK_HZ));

  // State register.
  always_ff @(posedge clk_50MHz) begin
    if (reset_button) state <= S_IDLE;
    else              state <= next_state;
  end

  // Next-state logic; stop overrides everything once playback is active.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (start && !stop) next_state = S_LOAD;
      S_LOAD: begin
        if (load_end) next_state = loop_en ? S_LOAD : S_DONE;
        else          next_state = S_PLAY;
      end
      S_PLAY: if (dur_zero) next_state = (GAP_CYCLES == 0) ? S_LOAD : S_GAP;
      S_GAP:  if (dur_zero) next_state = S_LOAD;
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    if (stop && (state != S_IDLE)) next_state = S_IDLE;
  end

  // Outputs; the divider is cleared whenever the next cycle is not PLAY so it leaves silent.
  always_comb begin
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
    note_code  = (state == S_PLAY) ? cur_code : 4'd0;
    tone_en    = (state == S_PLAY) && is_tone(cur_code);
    tone_clear = (next_state != S_PLAY);
  end

  // Song address, latched note code and the shared play/gap down-counter.
  always_ff @(posedge clk_50MHz) begin
    if (reset_button) begin
      addr     <= '0;
      dur_cnt  <= '0;
      cur_code <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          addr    <= '0;
          dur_cnt <= '0;
        end
        S_LOAD: begin
          cur_code <= rom_entry[7:4];
          dur_cnt  <= play_load;
          if (load_end) addr <= '0;
        end
        S_PLAY: begin
          if (dur_zero) begin
            dur_cnt <= GAP_LOAD;
            if (GAP_CYCLES == 0) addr <= addr + 1'b1;
          end else begin
            dur_cnt <= dur_cnt - 1'b1;
          end
        end
        S_GAP: begin
          if (dur_zero) addr <= addr + 1'b1;
          else          dur_cnt <= dur_cnt - 1'b1;
        end
        S_DONE: addr <= '0;
        default: addr <= '0;
      endcase
      if (stop && (state != S_IDLE)) begin
        addr    <= '0;
        dur_cnt <= '0;
      end
    end
  end

  tone_divider #(
    .TC_W(TC_W)
  ) u_tone_divider (
    .clk_50MHz    (clk_50MHz),
    .reset_button (reset_button),
    .clear        (tone_clear),
    .enable       (tone_en),
    .tc           (tc),
    .buzzer       (buzzer)
  );

endmodule

// File: tb/tb_melody_sequencer.sv
// tb/tb_melody_sequencer.sv - self-checking bench for melody_sequencer
module tb_melody_sequencer;

  localparam int CLK_HZ = 100_000;
  localparam int BEAT   = 1000;
  localparam int GAP    = 100;

  logic       clk_50MHz = 1'b0;
  logic       reset_button;
  logic       start;
  logic       stop;
  logic       loop_en;
  logic       buzzer;
  logic       busy;
  logic       done;
  logic [3:0] note_code;

  int errors = 0;
  int checks = 0;

  melody_sequencer #(
    .CLK_HZ      (CLK_HZ),
    .BEAT_CYCLES (BEAT),
    .GAP_CYCLES  (GAP),
    .SONG_LEN    (16)
  ) dut (
    .clk_50MHz    (clk_50MHz),
    .reset_button (reset_button),
    .start        (start),
    .stop         (stop),
    .loop_en      (loop_en),
    .buzzer       (buzzer),
    .busy         (busy),
    .done         (done),
    .note_code    (note_code)
  );

  always #5 clk_50MHz = ~clk_50MHz;

  // Expected song and note frequencies, written out independently of the design.
  int song_code[10]  = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 15};
  int song_beats[10] = '{2, 2, 2, 2, 2, 2, 2, 2, 1, 0};
  int hz_of[9]       = '{0, 262, 294, 330, 349, 392, 440, 494, 523};

  typedef struct {
    int         k;
    logic [3:0] code;
    bit         busy;
    bit         done;
    bit         buz;
  } vec_t;

  vec_t tbl[$];

  function automatic void add_vec(input int k, input int code, input bit b, input bit d, input bit z);
    vec_t v;
    v.k = k; v.code = 4'(code); v.busy = b; v.done = d; v.buz = z;
    tbl.push_back(v);
  endfunction

  // Timeline model: m = edges after the start edge; walks load/play/gap segments of each entry.
  function automatic void model(input int m, input bit lp, output bit e_busy,
                                output logic [3:0] e_code, output bit e_buz, output bit e_done);
    int pos;
    int a;
    int dur;
    int tc;
    pos = m; a = 0;
    e_busy = 1'b0; e_code = 4'd0; e_buz = 1'b0; e_done = 1'b0;
    for (int guard = 0; guard < 64; guard++) begin
      if (song_code[a] == 15) begin
        if (pos == 0) begin e_busy = 1'b1; return; end
        pos--;
        if (lp) begin a = 0; continue; end
        if (pos == 0) begin e_busy = 1'b1; e_done = 1'b1; end
        return;
      end
      if (pos == 0) begin e_busy = 1'b1; return; end
      pos--;
      dur = BEAT * song_beats[a];
      if (pos < dur) begin
        e_busy = 1'b1;
        e_code = 4'(song_code[a]);
        if (song_code[a] >= 1 && song_code[a] <= 8) begin
          tc = CLK_HZ / (2 * hz_of[song_code[a]]) - 1;
          e_buz = ((pos / (tc + 1)) % 2) == 1;
        end
        return;
      end
      pos -= dur;
      if (pos < GAP) begin e_busy = 1'b1; return; end
      pos -= GAP;
      a++;
    end
  endfunction

  task automatic check(input string name, input logic [3:0] c, input bit b, input bit d, input bit z);
    checks++;
    if (note_code !== c || busy !== b || done !== d || buzzer !== z) begin
      errors++;
      $display("FAIL %s: got code=%0d busy=%0b done=%0b buzzer=%0b, want code=%0d busy=%0b done=%0b buzzer=%0b",
               name, note_code, busy, done, buzzer, c, b, d, z);
    end
  endtask

  // Start playback and compare every cycle up to last_k; stop_k >= 0 asserts stop after that cycle.
  task automatic run_case(input bit lp, input int stop_k, input int last_k,
                          input bit hold, input bit noise, input bit use_tbl);
    bit         eb, ez, ed;
    logic [3:0] ec;
    int         idx;
    idx = 0;
    @(negedge clk_50MHz);
    start = 1'b1; stop = 1'b0; loop_en = lp;
    @(posedge clk_50MHz); #1;
    for (int k = 0; k <= last_k; k++) begin
      if (k > 0) begin
        @(negedge clk_50MHz);
        if (hold)       start = (k <= last_k - 6);
        else if (noise) start = 1'($urandom_range(0, 1));
        else            start = 1'b0;
        stop = (stop_k >= 0) && (k == stop_k + 1);
        @(posedge clk_50MHz); #1;
      end
      if (stop_k >= 0 && k == stop_k + 1) begin
        check($sformatf("stop_idle k=%0d", k), 4'd0, 1'b0, 1'b0, 1'b0);
        break;
      end
      model(k, lp, eb, ec, ez, ed);
      check($sformatf("model k=%0d loop=%0b", k, lp), ec, eb, ed, ez);
      if (use_tbl && idx < tbl.size() && tbl[idx].k == k) begin
        check($sformatf("vec k=%0d", k), tbl[idx].code, tbl[idx].busy, tbl[idx].done, tbl[idx].buz);
        idx++;
      end
    end
    @(negedge clk_50MHz);
    start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    repeat (3) @(posedge clk_50MHz);
  endtask

  initial begin
    // Hand-derived checkpoints for a one-shot run (k = edges after start edge).
    add_vec(0,     0, 1, 0, 0);
    add_vec(1,     1, 1, 0, 0);
    add_vec(190,   1, 1, 0, 0);
    add_vec(191,   1, 1, 0, 1);
    add_vec(2000,  1, 1, 0, 0);
    add_vec(2001,  0, 1, 0, 0);
    add_vec(2101,  0, 1, 0, 0);
    add_vec(2102,  2, 1, 0, 0);
    add_vec(4203,  3, 1, 0, 0);
    add_vec(4353,  3, 1, 0, 0);
    add_vec(4354,  3, 1, 0, 1);
    add_vec(4505,  3, 1, 0, 0);
    add_vec(16809, 0, 1, 0, 0);
    add_vec(17808, 0, 1, 0, 0);
    add_vec(17909, 0, 1, 0, 0);
    add_vec(17910, 0, 1, 1, 0);
    add_vec(17911, 0, 0, 0, 0);

    reset_button = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    repeat (3) @(posedge clk_50MHz);
    #1 check("reset_state", 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_50MHz);
    reset_button = 1'b0;

    // One-shot run with start held high throughout playback.
    run_case(1'b0, -1, 17911, 1'b1, 1'b0, 1'b1);

    // Stop at cycle 500 of entry 3's PLAY (entry 3 PLAY begins at k=6304).
    run_case(1'b0, 6803, 6804, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_50MHz); #1;
      check($sformatf("after_stop %0d", i), 4'd0, 1'b0, 1'b0, 1'b0);
    end

    // start and stop together in IDLE.
    @(negedge clk_50MHz);
    start = 1'b1; stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_50MHz); #1;
      check($sformatf("start_stop_idle %0d", i), 4'd0, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk_50MHz);
    start = 1'b0; stop = 1'b0;

    // Reset in the middle of the first note.
    @(negedge clk_50MHz); start = 1'b1;
    @(negedge clk_50MHz); start = 1'b0;
    repeat (300) @(negedge clk_50MHz);
    reset_button = 1'b1;
    @(posedge clk_50MHz); #1;
    check("reset_midplay", 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_50MHz);
    reset_button = 1'b0;
    repeat (2) @(posedge clk_50MHz);

    // Looped playback across the song boundary, then stopped.
    run_case(1'b1, 18200, 18201, 1'b0, 1'b0, 1'b0);

    // Random loop setting, random stop point, random start noise while busy.
    for (int r = 0; r < 4; r++) begin
      bit lp;
      int sk;
      lp = 1'($urandom_range(0, 1));
      sk = int'($urandom_range(1, 6000));
      run_case(lp, sk, sk + 1, 1'b0, 1'b1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
